// File: rtl/control_unit_pkg.sv
// Shared constants for the 4-bit uP control unit: opcodes, ALU functions and
// control-word bit positions.
package control_unit_pkg;

  localparam int unsigned OPCODE_W = 4;
  localparam int unsigned ALU_F_W  = 3;

  typedef enum logic [OPCODE_W-1:0] {
    OP_JC    = 4'b0000,
    OP_JNC   = 4'b0001,
    OP_CMPI  = 4'b0010,
    OP_CMPM  = 4'b0011,
    OP_LIT   = 4'b0100,
    OP_IN    = 4'b0101,
    OP_LD    = 4'b0110,
    OP_ST    = 4'b0111,
    OP_JZ    = 4'b1000,
    OP_JNZ   = 4'b1001,
    OP_ADDI  = 4'b1010,
    OP_ADDM  = 4'b1011,
    OP_JMP   = 4'b1100,
    OP_OUT   = 4'b1101,
    OP_NANDI = 4'b1110,
    OP_NANDM = 4'b1111
  } opcode_e;

  localparam logic [ALU_F_W-1:0] ALU_PASSA = 3'b000;
  localparam logic [ALU_F_W-1:0] ALU_SUB   = 3'b001;
  localparam logic [ALU_F_W-1:0] ALU_PASSB = 3'b010;
  localparam logic [ALU_F_W-1:0] ALU_ADD   = 3'b011;
  localparam logic [ALU_F_W-1:0] ALU_NAND  = 3'b100;

  localparam int unsigned CW_EN_PC    = 0;
  localparam int unsigned CW_LOAD_PC  = 1;
  localparam int unsigned CW_EN_FETCH = 2;
  localparam int unsigned CW_EN_ACCU  = 3;
  localparam int unsigned CW_OE_OPRND = 4;
  localparam int unsigned CW_OE_ALU   = 5;
  localparam int unsigned CW_OE_IN    = 6;
  localparam int unsigned CW_EN_OUT   = 7;
  localparam int unsigned CW_CS_RAM   = 8;
  localparam int unsigned CW_WE_RAM   = 9;
  localparam int unsigned CW_W        = 10;

endpackage

// File: rtl/control_unit_rom.sv
// Combinational decode of {instr, flags, phase} into the datapath control word,
// ALU function and flag-write enable.
module control_unit_rom
  import control_unit_pkg::*;
(
  input  logic [OPCODE_W-1:0] instr,
  input  logic                c_flag,
  input  logic                z_flag,
  input  logic                phase,
  output logic [CW_W-1:0]     ctrl,
  output logic [ALU_F_W-1:0]  alu_f,
  output logic                flags_en
);

  always_comb begin
    ctrl     = '0;
    alu_f    = ALU_PASSA;
    flags_en = 1'b0;
    if (!phase) begin
      ctrl[CW_EN_PC]    = 1'b1;
      ctrl[CW_EN_FETCH] = 1'b1;
    end else begin
      case (opcode_e'(instr))
        OP_JC:  ctrl[CW_LOAD_PC] = c_flag;
        OP_JNC: ctrl[CW_LOAD_PC] = ~c_flag;
        OP_JZ:  ctrl[CW_LOAD_PC] = z_flag;
        OP_JNZ: ctrl[CW_LOAD_PC] = ~z_flag;
        OP_JMP: ctrl[CW_LOAD_PC] = 1'b1;
        OP_CMPI: begin
          ctrl[CW_OE_OPRND] = 1'b1;
          alu_f             = ALU_SUB;
          flags_en          = 1'b1;
        end
        OP_CMPM: begin
          ctrl[CW_CS_RAM] = 1'b1;
          alu_f           = ALU_SUB;
          flags_en        = 1'b1;
        end
        OP_LIT: begin
          ctrl[CW_OE_OPRND] = 1'b1;
          ctrl[CW_EN_ACCU]  = 1'b1;
          alu_f             = ALU_PASSB;
        end
        OP_IN: begin
          ctrl[CW_OE_IN]   = 1'b1;
          ctrl[CW_EN_ACCU] = 1'b1;
          alu_f            = ALU_PASSB;
        end
        OP_LD: begin
          ctrl[CW_CS_RAM]  = 1'b1;
          ctrl[CW_EN_ACCU] = 1'b1;
          alu_f            = ALU_PASSB;
        end
        OP_ST: begin
          ctrl[CW_OE_ALU] = 1'b1;
          ctrl[CW_CS_RAM] = 1'b1;
          ctrl[CW_WE_RAM] = 1'b1;
        end
        OP_ADDI: begin
          ctrl[CW_OE_OPRND] = 1'b1;
          ctrl[CW_EN_ACCU]  = 1'b1;
          alu_f             = ALU_ADD;
          flags_en          = 1'b1;
        end
        OP_ADDM: begin
          ctrl[CW_CS_RAM]  = 1'b1;
          ctrl[CW_EN_ACCU] = 1'b1;
          alu_f            = ALU_ADD;
          flags_en         = 1'b1;
        end
        OP_OUT: begin
          ctrl[CW_OE_ALU] = 1'b1;
          ctrl[CW_EN_OUT] = 1'b1;
        end
        OP_NANDI: begin
          ctrl[CW_OE_OPRND] = 1'b1;
          ctrl[CW_EN_ACCU]  = 1'b1;
          alu_f             = ALU_NAND;
          flags_en          = 1'b1;
        end
        OP_NANDM: begin
          ctrl[CW_CS_RAM]  = 1'b1;
          ctrl[CW_EN_ACCU] = 1'b1;
          alu_f            = ALU_NAND;
          flags_en         = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/control_unit.sv
// Sequencer for the 4-bit uP: fetch/execute phase flop, C/Z flag register and
// run-enable gating wrapped around the decode ROM.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int unsigned OP_W = OPCODE_W,
  parameter int unsigned F_W  = ALU_F_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [OP_W-1:0] instr,
  input  logic            carry,
  input  logic            zero,
  output logic            phase,
  output logic            c_flag,
  output logic            z_flag,
  output logic            en_pc,
  output logic            load_pc,
  output logic            en_fetch,
  output logic            en_accu,
  output logic            oe_oprnd,
  output logic            oe_alu,
  output logic            oe_in,
  output logic            en_out,
  output logic            cs_ram,
  output logic            we_ram,
  output logic [F_W-1:0]  alu_f
);

  logic                phase_q, c_q, z_q;
  logic [CW_W-1:0]     rom_ctrl, ctrl;
  logic [ALU_F_W-1:0]  rom_f;
  logic                rom_flags_en;
  logic                active;

  control_unit_rom u_rom (
    .instr    (instr),
    .c_flag   (c_q),
    .z_flag   (z_q),
    .phase    (phase_q),
    .ctrl     (rom_ctrl),
    .alu_f    (rom_f),
    .flags_en (rom_flags_en)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q <= 1'b0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
    end else if (en) begin
      phase_q <= ~phase_q;
      if (phase_q && rom_flags_en) begin
        c_q <= carry;
        z_q <= zero;
      end
    end
  end

  // Reset is included so the fetch word does not leak out while held in reset.
  assign active = en & reset;

  always_comb begin
    ctrl  = '0;
    alu_f = ALU_PASSA;
    if (active) begin
      ctrl  = rom_ctrl;
      alu_f = rom_f;
    end
  end

  assign phase    = phase_q;
  assign c_flag   = c_q;
  assign z_flag   = z_q;
  assign en_pc    = ctrl[CW_EN_PC];
  assign load_pc  = ctrl[CW_LOAD_PC];
  assign en_fetch = ctrl[CW_EN_FETCH];
  assign en_accu  = ctrl[CW_EN_ACCU];
  assign oe_oprnd = ctrl[CW_OE_OPRND];
  assign oe_alu   = ctrl[CW_OE_ALU];
  assign oe_in    = ctrl[CW_OE_IN];
  assign en_out   = ctrl[CW_EN_OUT];
  assign cs_ram   = ctrl[CW_CS_RAM];
  assign we_ram   = ctrl[CW_WE_RAM];

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: behavioural model feeds a scoreboard
// queue, each scenario task pops and compares after driving a cycle.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic [3:0] instr = 4'h0;
  logic       carry = 1'b0;
  logic       zero = 1'b0;
  logic       phase, c_flag, z_flag, en_pc, load_pc, en_fetch, en_accu;
  logic       oe_oprnd, oe_alu, oe_in, en_out, cs_ram, we_ram;
  logic [2:0] alu_f;

  control_unit #(.OP_W(4), .F_W(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .instr    (instr),
    .carry    (carry),
    .zero     (zero),
    .phase    (phase),
    .c_flag   (c_flag),
    .z_flag   (z_flag),
    .en_pc    (en_pc),
    .load_pc  (load_pc),
    .en_fetch (en_fetch),
    .en_accu  (en_accu),
    .oe_oprnd (oe_oprnd),
    .oe_alu   (oe_alu),
    .oe_in    (oe_in),
    .en_out   (en_out),
    .cs_ram   (cs_ram),
    .we_ram   (we_ram),
    .alu_f    (alu_f)
  );

  always #5 clk = ~clk;

  // {phase, c, z, en_pc, load_pc, en_fetch, en_accu, oe_oprnd, oe_alu, oe_in,
  //  en_out, cs_ram, we_ram, alu_f}
  logic [15:0] outs;
  assign outs = {phase, c_flag, z_flag, en_pc, load_pc, en_fetch, en_accu, oe_oprnd,
                 oe_alu, oe_in, en_out, cs_ram, we_ram, alu_f};

  logic [15:0] sb[$];
  int checks = 0;
  int errors = 0;
  logic m_ph = 1'b0, m_c = 1'b0, m_z = 1'b0;

  function automatic bit writes_flags(input logic [3:0] op);
    return op inside {4'h2, 4'h3, 4'hA, 4'hB, 4'hE, 4'hF};
  endfunction

  function automatic logic [15:0] model(input logic act, input logic [3:0] op);
    logic pc, lp, fe, ac, oo, oa, oi, eo, cs, we;
    logic [2:0] f;
    {pc, lp, fe, ac, oo, oa, oi, eo, cs, we} = '0;
    f = 3'b000;
    if (act && !m_ph) begin
      pc = 1'b1;
      fe = 1'b1;
    end else if (act) begin
      case (op)
        4'h0: lp = m_c;
        4'h1: lp = !m_c;
        4'h8: lp = m_z;
        4'h9: lp = !m_z;
        4'hC: lp = 1'b1;
        4'h2: begin oo = 1; f = 3'b001; end
        4'h3: begin cs = 1; f = 3'b001; end
        4'h4: begin oo = 1; f = 3'b010; ac = 1; end
        4'h5: begin oi = 1; f = 3'b010; ac = 1; end
        4'h6: begin cs = 1; f = 3'b010; ac = 1; end
        4'h7: begin oa = 1; cs = 1; we = 1; end
        4'hA: begin oo = 1; f = 3'b011; ac = 1; end
        4'hB: begin cs = 1; f = 3'b011; ac = 1; end
        4'hD: begin oa = 1; eo = 1; end
        4'hE: begin oo = 1; f = 3'b100; ac = 1; end
        default: begin cs = 1; f = 3'b100; ac = 1; end
      endcase
    end
    return {m_ph, m_c, m_z, pc, lp, fe, ac, oo, oa, oi, eo, cs, we, f};
  endfunction

  // Drives one cycle at the falling edge, pushes the expected outputs, then
  // advances the model to the state the next rising edge will produce.
  task automatic step(input logic r, input logic e, input logic [3:0] op,
                      input logic cy, input logic zr);
    @(negedge clk);
    reset = r; en = e; instr = op; carry = cy; zero = zr;
    if (!r) begin m_ph = 0; m_c = 0; m_z = 0; end
    sb.push_back(model(e & r, op));
    #1;
    if (r && e) begin
      if (m_ph && writes_flags(op)) begin m_c = cy; m_z = zr; end
      m_ph = ~m_ph;
    end
  endtask

  task automatic test_reset();
    logic [4:0] tbl[6];
    logic [15:0] exp;
    // {reset, en, carry, zero, unused}; instr is ADDI throughout
    tbl = '{5'b01100, 5'b01100, 5'b11100, 5'b01100, 5'b11100, 5'b11100};
    for (int i = 0; i < 6; i++) begin
      step(tbl[i][4], tbl[i][3], 4'hA, tbl[i][2], tbl[i][1]);
      exp = sb.pop_front();
      checks++;
      if (outs !== exp) begin
        errors++;
        $display("FAIL reset[%0d] got=%h exp=%h", i, outs, exp);
      end
    end
  endtask

  task automatic test_addi_jumps();
    logic [5:0] tbl[8];
    logic [15:0] exp;
    // {op, carry, zero}
    tbl = '{{4'hA, 2'b10}, {4'h0, 2'b00}, {4'hA, 2'b01}, {4'h0, 2'b00},
            {4'h8, 2'b00}, {4'h1, 2'b00}, {4'h9, 2'b00}, {4'hC, 2'b00}};
    for (int i = 0; i < 8; i++) begin
      for (int p = 0; p < 2; p++) begin
        step(1'b1, 1'b1, tbl[i][5:2], tbl[i][1], tbl[i][0]);
        exp = sb.pop_front();
        checks++;
        if (outs !== exp) begin
          errors++;
          $display("FAIL addi_jumps[%0d.%0d] got=%h exp=%h", i, p, outs, exp);
        end
      end
    end
  endtask

  task automatic test_store_out();
    logic [3:0] ops[3];
    logic [15:0] exp;
    ops = '{4'h7, 4'hD, 4'h0};
    for (int i = 0; i < 3; i++) begin
      for (int p = 0; p < 2; p++) begin
        step(1'b1, 1'b1, ops[i], 1'b1, 1'b0);
        exp = sb.pop_front();
        checks++;
        if (outs !== exp) begin
          errors++;
          $display("FAIL store_out[%0d.%0d] got=%h exp=%h", i, p, outs, exp);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [2:0] tbl[8];
    logic [3:0] ops[8];
    logic [15:0] exp;
    // {en, carry, zero}: fetch CMPI, stall 3, execute, then JNZ/JC pair
    tbl = '{3'b111, 3'b000, 3'b000, 3'b000, 3'b111, 3'b100, 3'b100, 3'b100};
    ops = '{4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h9, 4'h9, 4'h0};
    for (int i = 0; i < 8; i++) begin
      step(1'b1, tbl[i][2], ops[i], tbl[i][1], tbl[i][0]);
      exp = sb.pop_front();
      checks++;
      if (outs !== exp) begin
        errors++;
        $display("FAIL stall[%0d] got=%h exp=%h", i, outs, exp);
      end
    end
    step(1'b1, 1'b1, 4'h0, 1'b0, 1'b0);
    exp = sb.pop_front();
    checks++;
    if (outs !== exp) begin
      errors++;
      $display("FAIL stall_jc got=%h exp=%h", outs, exp);
    end
  endtask

  task automatic test_sweep();
    logic [15:0] exp;
    logic [3:0] op;
    logic [1:0] fl;
    int busy;
    for (int o = 0; o < 16; o++) begin
      for (int f = 0; f < 4; f++) begin
        op = 4'(o);
        fl = 2'(f);
        for (int s = 0; s < 4; s++) begin
          if (s < 2) step(1'b1, 1'b1, 4'h2, fl[1], fl[0]);
          else step(1'b1, 1'b1, op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
          exp = sb.pop_front();
          busy = int'(oe_oprnd) + int'(oe_alu) + int'(oe_in) + int'(cs_ram & ~we_ram);
          checks++;
          if (outs !== exp) begin
            errors++;
            $display("FAIL sweep[op%0d f%0d s%0d] got=%h exp=%h", o, f, s, outs, exp);
          end
          checks++;
          if (busy > 1 || (we_ram && !cs_ram) || (load_pc && en_pc)) begin
            errors++;
            $display("FAIL invariant[op%0d f%0d s%0d] drivers=%0d we=%b cs=%b ld=%b pc=%b",
                     o, f, s, busy, we_ram, cs_ram, load_pc, en_pc);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_addi_jumps();
    test_store_out();
    test_stall();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
